// File: rtl/act_pkg.sv
// Shared activation helpers: slope defaults, saturation and parameter legality.
// Used by the forward leaky_relu and the backward leaky_relu_bwd stages.
package act_pkg;

  localparam int A_NUM_DEF = 1;
  localparam int A_DEN_DEF = 4;

  function automatic bit is_pow2(input int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit slope_ok(input int num, input int den);
    return is_pow2(den) && (num >= 0) && (num <= den);
  endfunction

  function automatic bit depth_ok(input int depth);
    return is_pow2(depth) && (depth >= 2);
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/sign_mask_fifo.sv
// 1-bit synchronous FIFO holding forward sign masks; head bit readable combinationally.
// Latency: push visible at head one edge later. Backpressure: full/empty from registered count only.
module sign_mask_fifo
  import act_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("sign_mask_fifo: DEPTH must be a power of two >= 2");
  end

  logic          mem_q [DEPTH];
  logic          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: 1'b0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/leaky_relu_bwd.sv
// Leaky-ReLU backward: gates returning gradients by the stored forward sign (slope 1 or A_NUM/A_DEN).
// Latency: one cycle from pop acceptance to grad_out. Backpressure: fwd_ready/grad_ready from FIFO count; no output stall.
module leaky_relu_bwd
  import act_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int A_NUM  = A_NUM_DEF,
  parameter int A_DEN  = A_DEN_DEF,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        fwd_data,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic [DATA_W-1:0]        grad_in,
  input  logic                     grad_valid,
  output logic                     grad_ready,
  output logic [DATA_W-1:0]        grad_out,
  output logic                     grad_out_valid,
  output logic [$clog2(DEPTH):0]   mask_count,
  output logic                     err_underflow
);

  localparam int PW = DATA_W + $clog2(A_NUM + 1) + 1;
  localparam int SH = $clog2(A_DEN);
  localparam logic signed [PW-1:0] A_NUM_S = PW'(A_NUM);

  if (!slope_ok(A_NUM, A_DEN)) begin : g_bad_slope
    $error("leaky_relu_bwd: need A_DEN power of two and 0 <= A_NUM <= A_DEN");
  end

  logic              fifo_full, fifo_empty, head_pass;
  logic              push, pop;
  logic signed [PW-1:0] grad_ext, prod, scaled;
  logic [DATA_W-1:0] grad_neg;

  logic [DATA_W-1:0] grad_out_q, grad_out_d;
  logic              grad_out_valid_q, grad_out_valid_d;
  logic              err_underflow_q, err_underflow_d;

  assign fwd_ready  = !fifo_full;
  assign grad_ready = !fifo_empty;
  assign push       = fwd_valid && fwd_ready;
  assign pop        = grad_valid && grad_ready;

  sign_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_mask_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (!fwd_data[DATA_W-1]),
    .pop   (pop),
    .dout  (head_pass),
    .count (mask_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Arithmetic shift after a full-precision product rounds toward minus infinity.
  always_comb begin
    grad_ext = {{(PW - DATA_W){grad_in[DATA_W-1]}}, grad_in};
    prod     = grad_ext * A_NUM_S;
    scaled   = prod >>> SH;
    grad_neg = DATA_W'(sat_s(64'(scaled), DATA_W));
  end

  always_comb begin
    grad_out_d       = grad_out_q;
    grad_out_valid_d = pop;
    err_underflow_d  = err_underflow_q || (grad_valid && !grad_ready);
    if (pop) begin
      grad_out_d = head_pass ? grad_in : grad_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grad_out_q       <= '0;
      grad_out_valid_q <= 1'b0;
      err_underflow_q  <= 1'b0;
    end else begin
      grad_out_q       <= grad_out_d;
      grad_out_valid_q <= grad_out_valid_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  assign grad_out       = grad_out_q;
  assign grad_out_valid = grad_out_valid_q;
  assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_leaky_relu_bwd.sv
// Directed bench for leaky_relu_bwd with default parameters (DATA_W=8, slope 1/4, DEPTH=16).
module tb_leaky_relu_bwd;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] fwd_data;
  logic              fwd_valid;
  logic              fwd_ready;
  logic signed [7:0] grad_in;
  logic              grad_valid;
  logic              grad_ready;
  logic signed [7:0] grad_out;
  logic              grad_out_valid;
  logic [4:0]        mask_count;
  logic              err_underflow;

  int n_checks = 0;
  int n_errors = 0;

  leaky_relu_bwd #(
    .DATA_W (8),
    .A_NUM  (1),
    .A_DEN  (4),
    .DEPTH  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fwd_data       (fwd_data),
    .fwd_valid      (fwd_valid),
    .fwd_ready      (fwd_ready),
    .grad_in        (grad_in),
    .grad_valid     (grad_valid),
    .grad_ready     (grad_ready),
    .grad_out       (grad_out),
    .grad_out_valid (grad_out_valid),
    .mask_count     (mask_count),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input int x, input int g);
    int p;
    if (x >= 0) return g;
    p = (g * 1) >>> 2;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return p;
  endfunction

  int fwd_vec [4] = '{16, 24, -16, -24};
  int grd_vec [4] = '{8, 8, 8, -20};
  int exp_vec [4] = '{8, 8, 2, -5};
  int fv [100];
  int gv [100];

  initial begin
    rst = 1'b0; fwd_data = '0; fwd_valid = 1'b0; grad_in = '0; grad_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();

    check("rst_grad_out", grad_out, 0);
    check("rst_out_valid", grad_out_valid, 0);
    check("rst_fwd_ready", fwd_ready, 1);
    check("rst_grad_ready", grad_ready, 0);
    check("rst_count", mask_count, 0);
    check("rst_err", err_underflow, 0);

    // Basic gating
    for (int i = 0; i < 4; i++) begin
      fwd_valid = 1'b1; fwd_data = 8'(fwd_vec[i]);
      step();
    end
    fwd_valid = 1'b0;
    check("basic_count4", mask_count, 4);
    for (int i = 0; i < 4; i++) begin
      grad_valid = 1'b1; grad_in = 8'(grd_vec[i]);
      step();
      check("basic_valid", grad_out_valid, 1);
      check($sformatf("basic_out%0d", i), grad_out, exp_vec[i]);
      check("basic_count", mask_count, 3 - i);
    end
    grad_valid = 1'b0;
    step();
    check("basic_pulse_end", grad_out_valid, 0);

    // Rounding toward -inf and zero forward input
    fwd_valid = 1'b1; fwd_data = -8'sd1; step(); fwd_valid = 1'b0;
    grad_valid = 1'b1; grad_in = -8'sd7; step(); grad_valid = 1'b0;
    check("round_neg1", grad_out, -2);
    fwd_valid = 1'b1; fwd_data = 8'sd0; step(); fwd_valid = 1'b0;
    grad_valid = 1'b1; grad_in = -8'sd7; step(); grad_valid = 1'b0;
    check("zero_pass", grad_out, -7);
    check("zero_count", mask_count, 0);

    // Full boundary
    fwd_valid = 1'b1; fwd_data = -8'sd16;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) check("full_ready15", fwd_ready, 1);
      if (i == 16) begin
        check("full_ready16", fwd_ready, 0);
        check("full_count16", mask_count, 16);
      end
    end
    check("full_count20", mask_count, 16);
    grad_valid = 1'b1; grad_in = 8'sd40;
    step();
    grad_valid = 1'b0;
    check("full_pop_count", mask_count, 15);
    check("full_pop_out", grad_out, 10);
    check("full_ready_back", fwd_ready, 1);
    step();
    fwd_valid = 1'b0;
    check("full_refill", mask_count, 16);
    grad_valid = 1'b1; grad_in = -8'sd128;
    for (int i = 0; i < 16; i++) step();
    grad_valid = 1'b0;
    check("drain_out_min", grad_out, -32);
    check("drain_count", mask_count, 0);

    // Underflow
    grad_valid = 1'b1; grad_in = 8'sd5;
    step();
    grad_valid = 1'b0;
    check("uf_no_out", grad_out_valid, 0);
    check("uf_err", err_underflow, 1);
    step(); step();
    check("uf_sticky", err_underflow, 1);
    rst = 1'b0; step(); rst = 1'b1;
    check("uf_cleared", err_underflow, 0);

    // Concurrent streaming, grads one cycle behind forward samples
    for (int i = 0; i < 100; i++) begin
      fv[i] = $urandom_range(255) - 128;
      gv[i] = $urandom_range(255) - 128;
    end
    for (int c = 0; c <= 100; c++) begin
      fwd_valid  = (c < 100);
      fwd_data   = (c < 100) ? 8'(fv[c]) : '0;
      grad_valid = (c >= 1);
      grad_in    = (c >= 1) ? 8'(gv[c-1]) : '0;
      if (c < 100) check("stream_fwd_ready", fwd_ready, 1);
      step();
      if (c >= 1) begin
        check("stream_valid", grad_out_valid, 1);
        check($sformatf("stream_out%0d", c - 1), grad_out, model(fv[c-1], gv[c-1]));
      end
      check("stream_count", mask_count, (c < 100) ? 1 : 0);
    end
    fwd_valid = 1'b0; grad_valid = 1'b0;
    step();
    check("stream_err", err_underflow, 0);

    // Reset during a pop
    fwd_valid = 1'b1; fwd_data = 8'sd3;
    for (int i = 0; i < 5; i++) step();
    fwd_valid = 1'b0;
    check("mid_count5", mask_count, 5);
    grad_valid = 1'b1; grad_in = 8'sd9; rst = 1'b0;
    step();
    rst = 1'b1; grad_valid = 1'b0;
    check("mid_valid", grad_out_valid, 0);
    check("mid_count", mask_count, 0);
    check("mid_grad_ready", grad_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/leaky_relu_bwd.md
# leaky_relu_bwd

Backward-pass counterpart of the forward `leaky_relu` activation. It captures the sign of every forward pre-activation sample into a 1-bit mask FIFO. It then gates the returning gradient stream: slope 1 where the forward input was non-negative, slope A_NUM/A_DEN where it was negative. It sits between the gradient output of the following layer and the gradient input of the preceding conv/FC stage, in the training data path.

## Interface
- `DATA_W`, 8: width of signed forward and gradient samples (two's complement).
- `A_NUM`, 1: negative-region slope numerator; must satisfy 0 ≤ A_NUM ≤ A_DEN.
- `A_DEN`, 4: negative-region slope denominator; power of two, ≥ 1.
- `DEPTH`, 16: mask FIFO entries; power of two, ≥ 2.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset: `rst`=0 sampled on a rising edge resets the block.
- `fwd_data`  in  DATA_W  forward pre-activation sample, the same value presented to `leaky_relu` `in_data`.
- `fwd_valid`  in  1  `fwd_data` is valid this cycle.
- `fwd_ready`  out  1  mask FIFO can accept a sample.
- `grad_in`  in  DATA_W  upstream gradient, in the same element order as the forward samples.
- `grad_valid`  in  1  `grad_in` is valid.
- `grad_ready`  out  1  a mask entry is available.
- `grad_out`  out  DATA_W  gated gradient.
- `grad_out_valid`  out  1  `grad_out` is valid; single-cycle pulse per element, no backpressure.
- `mask_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `err_underflow`  out  1  sticky; set when `grad_valid`=1 while `grad_ready`=0.

## Operation
- Push: on `fwd_valid & fwd_ready`, write mask bit `~fwd_data[DATA_W-1]` (1 = pass, x ≥ 0) at the write pointer.
- Pop: on `grad_valid & grad_ready`, read the head mask bit and compute the output:
  - mask=1: `grad_out` = `grad_in`.
  - mask=0: `grad_out` = (`grad_in` × A_NUM) >>> log2(A_DEN).
    - Full-precision product width is DATA_W + $clog2(A_NUM+1) + 1.
    - Arithmetic shift, so rounding is toward −∞.
    - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Zero input uses slope 1, since the mask is derived from the sign bit only.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- `mask_count` tracks occupancy:
  - +1 on push only; −1 on pop only.
  - Unchanged on a simultaneous push and pop.
- `fwd_ready` = (`mask_count` != DEPTH) and `grad_ready` = (`mask_count` != 0). Both derive from registered count only; there is no combinational path from the valid inputs.
- Full condition: a push is refused. A pop in the same cycle does not enable that push; `fwd_ready` rises the next cycle.
- Empty condition: `grad_valid` is ignored. No output is produced, and `err_underflow` is set on the next edge.
- A simultaneous push and pop at count 1 is legal. The pop uses the old head entry and the count stays at 1.
- Elaboration error when A_DEN is not a power of two, A_NUM > A_DEN, or DEPTH is not a power of two.

## Timing
- Reset values:
  - `grad_out`=0, `grad_out_valid`=0.
  - `fwd_ready`=1, `grad_ready`=0.
  - `mask_count`=0, `err_underflow`=0, pointers=0.
- Latency: a pop accepted at edge N produces registered `grad_out` / `grad_out_valid` visible after edge N, one cycle.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-operation:
  - Flushes the FIFO and clears `err_underflow`.
  - A pop accepted in the same cycle that `rst`=0 is sampled is discarded, so `grad_out_valid`=0 after that edge.
- `err_underflow` clears only on reset.

## Structure
- Shared package `act_pkg`:
  - Slope defaults (A_NUM/A_DEN).
  - Saturation function `sat_s(width)`.
  - Parameter-legality checks, shared with forward `leaky_relu`.
- Sub-module `sign_mask_fifo`: 1-bit wide synchronous FIFO with pointers, count, full and empty. The top level holds the slope datapath, the output register and the error flag.

## Test plan
- Defaults used unless stated (DATA_W=8, A=1/4, DEPTH=16).
- Basic gating: push fwd 16, 24, −16, −24; then send grad 8, 8, 8, −20 → grad_out 8, 8, 2, −5, each one cycle after acceptance; `mask_count` goes 4→0.
- Rounding and zero input: push fwd −1, then send grad −7 → −2. Push fwd 0, then send grad −7 → −7.
- Full boundary: hold `fwd_valid` for 20 cycles with no grads → `fwd_ready`=0 after the 16th push and `mask_count`=16. Then pop one with `fwd_valid` still high → no push that cycle; `fwd_ready`=1 the next cycle.
- Underflow: `grad_valid`=1 with empty FIFO → `grad_out_valid` stays 0 and `err_underflow`=1 from the next cycle until reset.
- Concurrent streaming: fwd and grad streams offset by 1 cycle for 100 random samples, checked against a reference model → no stalls, `mask_count` ≤ 1, outputs bit-exact.
- Reset mid-op: fill 5 entries, assert `rst`=0 for one cycle during a pop → `grad_out_valid`=0, `mask_count`=0, `grad_ready`=0 after the edge.
